uart_tx_serializer: RTL and testbench

//   Parametrised successor to the UART TX parallel-to-serial stage.
//   - Accepts data words on a valid/ready stream and buffers them in a DEPTH-entry FIFO.
//   - Builds each frame (start, 5..DATA_W data bits LSB first, optional parity, 1/2 stop).
//   - Shifts the frame out on tx, one bit per baud_tick.
//   - Sits between the host/bus interface and the baud generator in the UART TX path.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_fifo.sv | 58 +++++
 rtl/uart_tx_serializer.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART TX shared definitions: parity encodings, FSM states, frame-length limits.
// Pure definitions, no logic or latency.
// No flow control involved.
package uart_pkg;

  localparam int MIN_DATA_BITS = 5;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Requested data length pulled into the legal range [MIN_DATA_BITS, max_bits].
  function automatic logic [3:0] clamp_len(input logic [3:0] req, input int max_bits);
    if (int'(req) < MIN_DATA_BITS) return 4'(MIN_DATA_BITS);
    if (int'(req) > max_bits) return 4'(max_bits);
    return req;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Word buffer between the host stream and the TX framer (DATA_W x DEPTH).
// Latency: a pushed word is visible at pop_data one clk after the push edge.
// Backpressure: pushes while full are dropped (caller gates with !full); pops while empty ignored.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART TX serializer: buffers words and shifts out start/data/parity/stop frames on tx.
// Latency: first start bit appears on the first baud_tick after a word reaches the FIFO.
// Backpressure: s_ready = !fifo_full; back-to-back frames leave no idle bit while words remain.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [3:0]        data_len,
  input  logic [1:0]        parity_type,
  input  logic              stop_bits,
  output logic              tx,
  output logic              parity_out,
  output logic              tx_active,
  output logic              tx_done,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              fifo_full,
  output logic              fifo_empty
);

  tx_state_t         state;
  logic [DATA_W-1:0] shift_reg;
  logic [3:0]        bit_cnt;
  logic [3:0]        len_q;
  logic              par_en_q;
  logic              par_bit_q;
  logic              stop2_q;
  logic              stop_cnt;

  logic [DATA_W-1:0] head;
  logic [3:0]        cfg_len;
  logic              head_xor;
  logic              new_par_bit;
  logic              new_par_en;
  logic              final_stop;
  logic              load;

  assign s_ready = !fifo_full;

  uart_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s_valid),
    .push_data (s_data),
    .pop       (load),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cfg_len     = clamp_len(data_len, DATA_W);
  assign new_par_en  = (parity_type == PAR_ODD) || (parity_type == PAR_EVEN);
  assign new_par_bit = (parity_type == PAR_ODD) ? ~head_xor : head_xor;
  assign final_stop  = (stop_cnt == stop2_q);

  // A new frame starts from idle, or directly out of the last stop bit when words remain.
  assign load = baud_tick && !fifo_empty &&
                ((state == ST_IDLE) || ((state == ST_STOP) && final_stop));

  // XOR over only the data bits that will actually be sent.
  always_comb begin
    head_xor = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(cfg_len)) head_xor = head_xor ^ head[i];
    end
  end

  // Frame FSM with registered line outputs; every state change is gated by baud_tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      len_q      <= 4'(MIN_DATA_BITS);
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt   <= 1'b0;
      tx         <= 1'b1;
      tx_active  <= 1'b0;
      tx_done    <= 1'b0;
      parity_out <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (baud_tick) begin
        if (state == ST_STOP && final_stop) tx_done <= 1'b1;
        if (load) begin
          // Latch the whole frame configuration so mid-frame input changes wait a frame.
          shift_reg  <= head;
          len_q      <= cfg_len;
          par_en_q   <= new_par_en;
          par_bit_q  <= new_par_bit;
          parity_out <= new_par_bit;
          stop2_q    <= stop_bits;
          stop_cnt   <= 1'b0;
          bit_cnt    <= '0;
          tx         <= 1'b0;
          tx_active  <= 1'b1;
          state      <= ST_START;
        end else begin
          case (state)
            ST_IDLE: begin
              tx <= 1'b1;
            end
            ST_START: begin
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= 4'd1;
              state     <= ST_DATA;
            end
            ST_DATA: begin
              if (bit_cnt == len_q) begin
                if (par_en_q) begin
                  tx    <= par_bit_q;
                  state <= ST_PARITY;
                end else begin
                  tx       <= 1'b1;
                  stop_cnt <= 1'b0;
                  state    <= ST_STOP;
                end
              end else begin
                tx        <= shift_reg[0];
                shift_reg <= shift_reg >> 1;
                bit_cnt   <= bit_cnt + 4'd1;
              end
            end
            ST_PARITY: begin
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= ST_STOP;
            end
            ST_STOP: begin
              if (final_stop) begin
                tx        <= 1'b1;
                tx_active <= 1'b0;
                state     <= ST_IDLE;
              end else begin
                stop_cnt <= 1'b1;
              end
            end
            default: begin
              tx        <= 1'b1;
              tx_active <= 1'b0;
              state     <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: fixed frame vectors, multi-frame corner cases, random frames vs a bit-list model.
// Latency: checks each transmitted bit right after the baud_tick that launches it.
// Backpressure: exercises FIFO fill to full and the dropped extra push.
module tb_uart_tx_serializer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              baud_tick;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [3:0]        data_len;
  logic [1:0]        parity_type;
  logic              stop_bits;
  logic              tx;
  logic              parity_out;
  logic              tx_active;
  logic              tx_done;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  uart_tx_serializer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .data_len    (data_len),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
    .tx          (tx),
    .parity_out  (parity_out),
    .tx_active   (tx_active),
    .tx_done     (tx_done),
    .fifo_count  (fifo_count),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic exp_q[$];

  // Count every tx_done pulse, sampled mid-cycle.
  always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic bt);
    @(negedge clk);
    baud_tick = bt;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    @(negedge clk);
    baud_tick = 1'b0;
    s_data    = w;
    s_valid   = 1'b1;
    @(posedge clk);
    #1;
    s_valid   = 1'b0;
  endtask

  // Reference: a frame is just the list of line levels, built from the framing rules.
  function automatic void add_frame(input logic [7:0] w, input int len, input int pt, input bit st);
    int nbits;
    int ones;
    nbits = (len < 5) ? 5 : ((len > 8) ? 8 : len);
    ones  = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      exp_q.push_back(w[i]);
      ones += int'(w[i]);
    end
    if (pt == 1) exp_q.push_back((ones % 2) == 0);
    if (pt == 2) exp_q.push_back((ones % 2) == 1);
    exp_q.push_back(1'b1);
    if (st) exp_q.push_back(1'b1);
  endfunction

  function automatic logic model_parity(input logic [7:0] w, input int len, input int pt);
    int nbits;
    int ones;
    nbits = (len < 5) ? 5 : ((len > 8) ? 8 : len);
    ones  = 0;
    for (int i = 0; i < nbits; i++) ones += int'(w[i]);
    return (pt == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  // Tick through every queued bit, checking the line after each tick, then the frame end.
  task automatic play(input int gap_max, input string nm, input int cfg_k, input logic [1:0] cfg_pt);
    int   n;
    logic prev;
    n    = exp_q.size();
    prev = 1'b1;
    for (int k = 0; k < n; k++) begin
      int gaps;
      gaps = $urandom_range(gap_max, 0);
      for (int g = 0; g < gaps; g++) begin
        step(1'b0);
        chk($sformatf("%s_hold%0d", nm, k), tx, prev);
      end
      step(1'b1);
      chk($sformatf("%s_bit%0d", nm, k), tx, exp_q[k]);
      chk($sformatf("%s_active%0d", nm, k), tx_active, 1'b1);
      prev = exp_q[k];
      if (k == cfg_k) parity_type = cfg_pt;
    end
    step(1'b1);
    chk($sformatf("%s_done", nm), tx_done, 1'b1);
    chk($sformatf("%s_idle_active", nm), tx_active, 1'b0);
    chk($sformatf("%s_idle_tx", nm), tx, 1'b1);
    step(1'b0);
    chk($sformatf("%s_done_pulse", nm), tx_done, 1'b0);
    exp_q.delete();
  endtask

  typedef struct {
    logic [7:0] w;
    logic [3:0] len;
    logic [1:0] pt;
    logic       st;
    string      bits;
    logic       chk_par;
    logic       par;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          d0;
    logic [7:0]  words[5];

    vecs[0] = '{8'hA5, 4'd8,  2'b00, 1'b0, "0101001011",   1'b0, 1'b0};
    vecs[1] = '{8'h55, 4'd7,  2'b10, 1'b1, "01010101011",  1'b1, 1'b0};
    vecs[2] = '{8'hFF, 4'd5,  2'b01, 1'b0, "01111101",     1'b1, 1'b0};
    vecs[3] = '{8'h0B, 4'd0,  2'b11, 1'b0, "0110101",      1'b0, 1'b0};
    vecs[4] = '{8'h80, 4'd15, 2'b01, 1'b1, "000000001011", 1'b1, 1'b0};

    // Reset held with s_valid asserted: nothing may enter the FIFO.
    rst = 1'b1; baud_tick = 1'b0; s_valid = 1'b1; s_data = 8'h3C;
    data_len = 4'd8; parity_type = 2'b00; stop_bits = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_active", tx_active, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_parity", parity_out, 1'b0);
    chk("rst_ready", s_ready, 1'b1);
    chk("rst_empty", fifo_empty, 1'b1);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_count", fifo_count, 0);
    @(negedge clk);
    s_valid = 1'b0;
    rst     = 1'b0;
    step(1'b1);
    chk("post_rst_empty", fifo_empty, 1'b1);
    chk("post_rst_tx", tx, 1'b1);
    chk("post_rst_active", tx_active, 1'b0);

    // Fixed frame vectors.
    for (int v = 0; v < 5; v++) begin
      data_len    = vecs[v].len;
      parity_type = vecs[v].pt;
      stop_bits   = vecs[v].st;
      push(vecs[v].w);
      for (int i = 0; i < vecs[v].bits.len(); i++) exp_q.push_back(vecs[v].bits[i] == 8'h31);
      d0 = done_cnt;
      play(0, $sformatf("vec%0d", v), -1, 2'b00);
      chk($sformatf("vec%0d_done_count", v), done_cnt - d0, 1);
      if (vecs[v].chk_par) chk($sformatf("vec%0d_parity_out", v), parity_out, vecs[v].par);
    end

    // Fill the FIFO while idle; the fifth push must be dropped.
    data_len = 4'd8; parity_type = 2'b00; stop_bits = 1'b0;
    for (int i = 0; i < 5; i++) begin
      words[i] = 8'($urandom);
      push(words[i]);
      chk($sformatf("fill_count%0d", i), fifo_count, (i < 4) ? i + 1 : 4);
    end
    chk("fill_ready", s_ready, 1'b0);
    chk("fill_full", fifo_full, 1'b1);
    for (int i = 0; i < 4; i++) add_frame(words[i], 8, 0, 1'b0);
    d0 = done_cnt;
    play(0, "b2b", -1, 2'b00);
    chk("b2b_done_count", done_cnt - d0, 4);
    chk("b2b_empty", fifo_empty, 1'b1);

    // Parity enabled mid-frame applies only from the next frame.
    words[0] = 8'($urandom);
    words[1] = 8'($urandom);
    push(words[0]);
    push(words[1]);
    add_frame(words[0], 8, 0, 1'b0);
    add_frame(words[1], 8, 2, 1'b0);
    play(1, "cfgchg", 2, 2'b10);
    chk("cfgchg_parity_out", parity_out, model_parity(words[1], 8, 2));
    parity_type = 2'b00;

    // Reset during data bit 3 abandons the frame and flushes the FIFO.
    push(8'hF0);
    push(8'h3C);
    repeat (5) step(1'b1);
    chk("mid_rst_bit3", tx, 1'b0);
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_active", tx_active, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1);
      chk($sformatf("mid_rst_quiet%0d", i), tx, 1'b1);
    end
    chk("mid_rst_no_done", done_cnt - d0, 0);
    push(8'h5A);
    add_frame(8'h5A, 8, 0, 1'b0);
    play(0, "after_rst", -1, 2'b00);

    // Random frames against the model, with irregular baud spacing.
    for (int r = 0; r < 25; r++) begin
      logic [7:0] w;
      int         len;
      int         pt;
      bit         st;
      w   = 8'($urandom);
      len = $urandom_range(15, 0);
      pt  = $urandom_range(3, 0);
      st  = 1'($urandom_range(1, 0));
      data_len    = 4'(len);
      parity_type = 2'(pt);
      stop_bits   = st;
      push(w);
      add_frame(w, len, pt, st);
      play(2, $sformatf("rand%0d", r), -1, 2'b00);
      if (pt == 1 || pt == 2)
        chk($sformatf("rand%0d_parity_out", r), parity_out, model_parity(w, len, pt));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so a stuck design still ends with a verdict.
  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
